// File: rtl/div4_iter_sched_pkg.sv
// Shared widths, FSM state encoding and round-robin grant helper for the
// iterative 4-bit by 2-bit divider front end.
package div4_pkg;

  localparam int DIVIDEND_W = 4;
  localparam int DIVISOR_W  = 2;
  localparam int REM_W      = 3;
  localparam int NUM_REQ    = 2;
  localparam int STEPS      = 4;
  localparam int CNT_W      = $clog2(STEPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A lone requester always wins; on contention the pointer decides.
  function automatic logic rr_grant(input logic [NUM_REQ-1:0] valid, input logic ptr);
    return (valid[0] ^ valid[1]) ? valid[1] : ptr;
  endfunction

endpackage

// File: rtl/div4_iter_sched_if.sv
// Request/response bundle between the requesting pipelines and the shared
// divider; master = requesters plus result consumer, slave = the divider.
interface div4_iter_sched_if;
  import div4_pkg::*;

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0][DIVIDEND_W-1:0] req_a;
  logic [NUM_REQ-1:0][DIVISOR_W-1:0]  req_b;
  logic                               rsp_valid;
  logic                               rsp_ready;
  logic [DIVIDEND_W-1:0]              rsp_q;
  logic [DIVISOR_W-1:0]               rsp_r;
  logic                               rsp_id;
  logic                               rsp_dz;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_q, rsp_r, rsp_id, rsp_dz
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_q, rsp_r, rsp_id, rsp_dz
  );

endinterface

// File: rtl/div4_iter_sched_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only when it is non-negative.
module div4_step
  import div4_pkg::*;
(
  input  logic [REM_W-1:0]     rem_i,
  input  logic                 a_bit_i,
  input  logic [DIVISOR_W-1:0] b_i,
  output logic [REM_W-1:0]     rem_next_o,
  output logic                 q_bit_o
);

  logic [REM_W-1:0] t;
  logic [REM_W:0]   trial;

  // The partial remainder never needs its MSB: only two bits shift into t.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_i[REM_W-1];

  always_comb begin
    t     = {rem_i[REM_W-2:0], a_bit_i};
    trial = {1'b0, t} - {{(REM_W + 1 - DIVISOR_W){1'b0}}, b_i};
    if (!trial[REM_W]) begin
      rem_next_o = trial[REM_W-1:0];
      q_bit_o    = 1'b1;
    end else begin
      rem_next_o = t;
      q_bit_o    = 1'b0;
    end
  end

endmodule

// File: rtl/div4_iter_sched.sv
// Two-requester round-robin front end sharing one restoring step unit: 5-cycle latency,
// result held in DONE until rsp_ready. DIV4_ZERO_CHK_EN short-cuts B==0 to DONE with rsp_dz.
module div4_iter_sched
  import div4_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  div4_iter_sched_if.slave bus
);

  state_e                 state_q, state_d;
  logic                   rr_ptr_q, rr_ptr_d;
  logic [DIVIDEND_W-1:0]  a_q, a_d;
  logic [DIVISOR_W-1:0]   b_q, b_d;
  logic                   id_q, id_d;
  logic [REM_W-1:0]       rem_q, rem_d;
  logic [DIVIDEND_W-1:0]  quot_q, quot_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
`ifdef DIV4_ZERO_CHK_EN
  logic                   dz_q, dz_d;
`endif

  logic                   grant;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   accept;
  logic [REM_W-1:0]       step_rem;
  logic                   step_q;

  assign grant = rr_grant(bus.req_valid, rr_ptr_q);

  always_comb begin
    req_ready = '0;
    if (!rst && state_q == IDLE) begin
      req_ready[grant] = 1'b1;
    end
  end

  assign accept        = |(bus.req_valid & req_ready);
  assign bus.req_ready = req_ready;

  div4_step u_step (
    .rem_i      (rem_q),
    .a_bit_i    (a_q[DIVIDEND_W-1]),
    .b_i        (b_q),
    .rem_next_o (step_rem),
    .q_bit_o    (step_q)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    cnt_d    = cnt_q;
`ifdef DIV4_ZERO_CHK_EN
    dz_d     = dz_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d      = bus.req_a[grant];
          b_d      = bus.req_b[grant];
          id_d     = grant;
          rem_d    = '0;
          quot_d   = '0;
          cnt_d    = '0;
          rr_ptr_d = ~grant;
          state_d  = RUN;
`ifdef DIV4_ZERO_CHK_EN
          dz_d     = 1'b0;
          if (bus.req_b[grant] == '0) begin
            quot_d  = '1;
            dz_d    = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      RUN: begin
        // Dividend shifts left so the step unit always sees the current MSB.
        rem_d  = step_rem;
        quot_d = {quot_q[DIVIDEND_W-2:0], step_q};
        a_d    = {a_q[DIVIDEND_W-2:0], 1'b0};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      rem_q    <= '0;
      quot_q   <= '0;
      cnt_q    <= '0;
`ifdef DIV4_ZERO_CHK_EN
      dz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      cnt_q    <= cnt_d;
`ifdef DIV4_ZERO_CHK_EN
      dz_q     <= dz_d;
`endif
    end
  end

  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_q     = quot_q;
  assign bus.rsp_r     = rem_q[DIVISOR_W-1:0];
  assign bus.rsp_id    = id_q;
`ifdef DIV4_ZERO_CHK_EN
  assign bus.rsp_dz    = dz_q;
`else
  assign bus.rsp_dz    = 1'b0;
`endif

endmodule
